// File: rtl/window_3_3_ctrl_pkg.sv
// Shared tap indices, border masks and sequencer state encoding for the
// 3x3 window frame controller.
package window_3_3_ctrl_pkg;

    localparam int TAP11 = 8;
    localparam int TAP12 = 7;
    localparam int TAP13 = 6;
    localparam int TAP21 = 5;
    localparam int TAP22 = 4;
    localparam int TAP23 = 3;
    localparam int TAP31 = 2;
    localparam int TAP32 = 1;
    localparam int TAP33 = 0;

    // Taps that fall outside the image on each border.
    localparam logic [8:0] MASK_TOP   = 9'h1C0;
    localparam logic [8:0] MASK_BOT   = 9'h007;
    localparam logic [8:0] MASK_LEFT  = 9'h124;
    localparam logic [8:0] MASK_RIGHT = 9'h049;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic logic [8:0] border_mask(input logic top, input logic bot,
                                               input logic left, input logic right);
        logic [8:0] m;
        m = 9'h1FF;
        if (top)   m = m & ~MASK_TOP;
        if (bot)   m = m & ~MASK_BOT;
        if (left)  m = m & ~MASK_LEFT;
        if (right) m = m & ~MASK_RIGHT;
        return m;
    endfunction

endpackage

// File: rtl/window_pos_cnt.sv
// Wrapping column/row position counter; load returns to (0,0) and wins over en.
module window_pos_cnt #(
    parameter int COLS  = 720,
    parameter int ROWS  = 576,
    parameter int COL_W = 11,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/window_3_3_ctrl.sv
// Frame sequencer and border controller beside the 3x3 window generator:
// tracks the centre pixel, masks/pads border taps, flags frame end and errors.
module window_3_3_ctrl
    import window_3_3_ctrl_pkg::*;
#(
    parameter int IMG_W    = 720,
    parameter int IMG_H    = 576,
    parameter int PERIOD_X = 864,
    parameter int PAD_ZERO = 1
) (
    input  logic        iclk,
    input  logic        rst_i,
    input  logic        ifs,
    input  logic        ivalid,
    input  logic        wvalid,
    input  logic [71:0] wdata,
    output logic        ovalid,
    output logic [71:0] odata_3_3,
    output logic [8:0]  omask,
    output logic [10:0] ocol,
    output logic [9:0]  orow,
    output logic        oframe_done,
    output logic        oerr,
    output logic        obusy
);

    localparam int IN_W = $clog2(IMG_W * IMG_H + 1);
    localparam int DR_W = $clog2(2 * PERIOD_X + 1);
    localparam logic [IN_W-1:0] FRAME_PIX = IN_W'(IMG_W * IMG_H);
    localparam logic [DR_W-1:0] DRAIN_MAX = DR_W'(2 * PERIOD_X);
    localparam logic [10:0]     COL_LAST  = 11'(IMG_W - 1);
    localparam logic [9:0]      ROW_LAST  = 10'(IMG_H - 1);

    state_t          state;
    logic [IN_W-1:0] in_cnt;
    logic [DR_W-1:0] drain_cnt;
    logic [DR_W-1:0] drain_nxt;
    logic [10:0]     pos_col;
    logic [9:0]      pos_row;
    logic            pos_last;
    logic            centre_hit;
    logic            frame_last;
    logic            pos_load;
    logic [8:0]      mask;
    logic [71:0]     padded;

    assign centre_hit = wvalid && (state != IDLE);
    assign frame_last = centre_hit && pos_last && (state == DRAIN);
    assign pos_load   = (state == IDLE) ? (ifs && ivalid) : ifs;
    assign drain_nxt  = drain_cnt + DR_W'(1);

    window_pos_cnt #(
        .COLS  (IMG_W),
        .ROWS  (IMG_H),
        .COL_W (11),
        .ROW_W (10)
    ) u_centre (
        .clk   (iclk),
        .rst_n (rst_i),
        .en    (centre_hit),
        .load  (pos_load),
        .col   (pos_col),
        .row   (pos_row),
        .last  (pos_last)
    );

    always_comb begin
        mask   = border_mask(pos_row == 10'd0, pos_row == ROW_LAST,
                             pos_col == 11'd0, pos_col == COL_LAST);
        padded = wdata;
        for (int k = 0; k < 9; k++) begin
            if ((PAD_ZERO != 0) && !mask[k]) padded[k*8 +: 8] = 8'h00;
        end
    end

    always_ff @(posedge iclk or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            in_cnt      <= '0;
            drain_cnt   <= '0;
            ovalid      <= 1'b0;
            odata_3_3   <= '0;
            omask       <= '0;
            ocol        <= '0;
            orow        <= '0;
            oframe_done <= 1'b0;
            oerr        <= 1'b0;
            obusy       <= 1'b0;
        end else begin
            oframe_done <= 1'b0;
            oerr        <= 1'b0;
            ovalid      <= centre_hit;
            if (centre_hit) begin
                ocol      <= pos_col;
                orow      <= pos_row;
                omask     <= mask;
                odata_3_3 <= padded;
            end

            case (state)
                IDLE: begin
                    if (ifs && ivalid) begin
                        state  <= ACTIVE;
                        obusy  <= 1'b1;
                        in_cnt <= IN_W'(1);
                    end
                end
                ACTIVE: begin
                    if (ifs) begin
                        oerr   <= 1'b1;
                        in_cnt <= ivalid ? IN_W'(1) : '0;
                    end else if (ivalid) begin
                        in_cnt <= in_cnt + IN_W'(1);
                        if (in_cnt + IN_W'(1) == FRAME_PIX) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_nxt;
                    // An ifs landing on the last centre pixel is a clean back-to-back frame.
                    if (ifs) begin
                        oframe_done <= frame_last;
                        oerr        <= !frame_last;
                        state       <= ACTIVE;
                        in_cnt      <= ivalid ? IN_W'(1) : '0;
                        drain_cnt   <= '0;
                    end else if (frame_last) begin
                        oframe_done <= 1'b1;
                        oerr        <= ivalid;
                        state       <= IDLE;
                        obusy       <= 1'b0;
                        in_cnt      <= '0;
                        drain_cnt   <= '0;
                    end else if (drain_nxt == DRAIN_MAX) begin
                        oerr      <= 1'b1;
                        state     <= IDLE;
                        obusy     <= 1'b0;
                        in_cnt    <= '0;
                        drain_cnt <= '0;
                    end else if (ivalid) begin
                        oerr <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    obusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_3_3_ctrl.sv
// Directed bench for window_3_3_ctrl on a 4x3 image with a delay-line window model.
module tb_window_3_3_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PX = 6;

    logic        iclk = 1'b0;
    logic        rst_i = 1'b0;
    logic        ifs = 1'b0;
    logic        ivalid = 1'b0;
    logic        wv_force = 1'b0;
    logic        win_en = 1'b1;
    logic [71:0] wdata = '1;
    logic [6:0]  vdly = '0;
    logic        wvalid;

    logic        ovalid, oframe_done, oerr, obusy;
    logic [71:0] odata_3_3;
    logic [8:0]  omask;
    logic [10:0] ocol;
    logic [9:0]  orow;

    logic        np_ovalid, np_done, np_err, np_busy;
    logic [71:0] np_data;
    logic [8:0]  np_mask;
    logic [10:0] np_col;
    logic [9:0]  np_row;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_last   = 0;

    int          n_ov, n_err, n_done, err_cyc, np_n;
    logic [10:0] lc[64];
    logic [9:0]  lr[64];
    logic [8:0]  lm[64];
    logic        ld[64];
    logic [71:0] ldat[64];
    logic [71:0] np_dat0;
    logic [8:0]  np_mask0;

    // Centre tap of a 3x3 window appears one line plus one pixel after the input.
    assign wvalid = (win_en & vdly[6]) | wv_force;

    window_3_3_ctrl #(.IMG_W(W), .IMG_H(H), .PERIOD_X(PX), .PAD_ZERO(1)) dut (
        .iclk(iclk), .rst_i(rst_i), .ifs(ifs), .ivalid(ivalid), .wvalid(wvalid),
        .wdata(wdata), .ovalid(ovalid), .odata_3_3(odata_3_3), .omask(omask),
        .ocol(ocol), .orow(orow), .oframe_done(oframe_done), .oerr(oerr), .obusy(obusy)
    );

    window_3_3_ctrl #(.IMG_W(W), .IMG_H(H), .PERIOD_X(PX), .PAD_ZERO(0)) dut_np (
        .iclk(iclk), .rst_i(rst_i), .ifs(ifs), .ivalid(ivalid), .wvalid(wvalid),
        .wdata(wdata), .ovalid(np_ovalid), .odata_3_3(np_data), .omask(np_mask),
        .ocol(np_col), .orow(np_row), .oframe_done(np_done), .oerr(np_err), .obusy(np_busy)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        cyc  <= cyc + 1;
        vdly <= {vdly[5:0], ivalid};
    end

    always @(negedge iclk) begin
        if (ovalid && n_ov < 64) begin
            lc[n_ov]   = ocol;
            lr[n_ov]   = orow;
            lm[n_ov]   = omask;
            ld[n_ov]   = oframe_done;
            ldat[n_ov] = odata_3_3;
            n_ov++;
        end
        if (oerr) begin
            n_err++;
            err_cyc = cyc;
        end
        if (oframe_done) n_done++;
        if (np_ovalid) begin
            if (np_n == 0) begin
                np_dat0  = np_data;
                np_mask0 = np_mask;
            end
            np_n++;
        end
    end

    task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle(input int n);
        ifs    = 1'b0;
        ivalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic feed(input int n, input bit with_fs);
        for (int i = 0; i < n; i++) begin
            ifs    = with_fs && (i == 0);
            ivalid = 1'b1;
            t_last = cyc;
            tick();
        end
        ifs    = 1'b0;
        ivalid = 1'b0;
    endtask

    task automatic clear_log();
        n_ov    = 0;
        n_err   = 0;
        n_done  = 0;
        err_cyc = -1;
        np_n    = 0;
    endtask

    initial begin
        clear_log();
        #12;
        check_val("rst_ctl", 72'({ovalid, omask, ocol, orow, oframe_done, oerr, obusy}), 72'd0);
        check_val("rst_data", odata_3_3, 72'd0);
        @(posedge iclk);
        #1;
        rst_i = 1'b1;
        idle(2);

        // Full frame with border masks and padding
        clear_log();
        feed(3, 1'b1);
        check_val("busy_active", 72'(obusy), 72'd1);
        feed(9, 1'b0);
        idle(20);
        check_val("full_n_ov", 72'(n_ov), 72'd12);
        check_val("first_pos", 72'({lc[0], lr[0]}), 72'({11'd0, 10'd0}));
        check_val("first_mask", 72'(lm[0]), 72'h01B);
        check_val("pad_zero_data", ldat[0], 72'h00_00_00_00_FF_FF_00_FF_FF);
        check_val("nopad_data", np_dat0, {72{1'b1}});
        check_val("nopad_mask", 72'(np_mask0), 72'h01B);
        check_val("top_right_mask", 72'({lc[3], lr[3], lm[3]}), 72'({11'd3, 10'd0, 9'h036}));
        check_val("left_mask", 72'({lc[4], lr[4], lm[4]}), 72'({11'd0, 10'd1, 9'h0DB}));
        check_val("centre_mask", 72'({lc[5], lr[5], lm[5]}), 72'({11'd1, 10'd1, 9'h1FF}));
        check_val("last_centre", 72'({lc[11], lr[11], lm[11], ld[11]}),
                  72'({11'd3, 10'd2, 9'h1B0, 1'b1}));
        check_val("full_done", 72'(n_done), 72'd1);
        check_val("full_err", 72'(n_err), 72'd0);
        check_val("full_busy_end", 72'(obusy), 72'd0);

        // ivalid while draining
        clear_log();
        feed(12, 1'b1);
        idle(1);
        feed(1, 1'b0);
        idle(20);
        check_val("drain_iv_err", 72'(n_err), 72'd1);
        check_val("drain_iv_done", 72'(n_done), 72'd1);
        check_val("drain_iv_n_ov", 72'(n_ov), 72'd12);

        // ifs after 5 pixels restarts the frame
        clear_log();
        feed(5, 1'b1);
        idle(10);
        check_val("partial_n_ov", 72'(n_ov), 72'd5);
        clear_log();
        feed(12, 1'b1);
        idle(20);
        check_val("restart_err", 72'(n_err), 72'd1);
        check_val("restart_pos", 72'({lc[0], lr[0]}), 72'({11'd0, 10'd0}));
        check_val("restart_n_ov", 72'(n_ov), 72'd12);
        check_val("restart_done", 72'(n_done), 72'd1);

        // Next ifs coincident with the last centre pixel
        clear_log();
        feed(12, 1'b1);
        idle(6);
        feed(12, 1'b1);
        idle(20);
        check_val("b2b_err", 72'(n_err), 72'd0);
        check_val("b2b_done", 72'(n_done), 72'd2);
        check_val("b2b_n_ov", 72'(n_ov), 72'd24);
        check_val("b2b_edge", 72'({ld[11], lc[12], lr[12]}), 72'({1'b1, 11'd0, 10'd0}));

        // Asynchronous reset mid-frame, then wvalid without ifs
        clear_log();
        feed(8, 1'b1);
        check_val("pre_rst_busy", 72'(obusy), 72'd1);
        #3;
        rst_i = 1'b0;
        #1;
        check_val("async_rst_ctl", 72'({ovalid, omask, ocol, orow, oframe_done, oerr, obusy}), 72'd0);
        check_val("async_rst_data", odata_3_3, 72'd0);
        idle(2);
        rst_i = 1'b1;
        clear_log();
        idle(10);
        wv_force = 1'b1;
        idle(3);
        wv_force = 1'b0;
        idle(2);
        check_val("idle_wvalid_n_ov", 72'(n_ov), 72'd0);
        check_val("idle_busy", 72'(obusy), 72'd0);

        // Drain timeout with the window removed
        clear_log();
        win_en = 1'b0;
        feed(12, 1'b1);
        idle(20);
        check_val("timeout_cyc", 72'(err_cyc), 72'(t_last + 13));
        check_val("timeout_err", 72'(n_err), 72'd1);
        check_val("timeout_done", 72'(n_done), 72'd0);
        check_val("timeout_busy", 72'(obusy), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_3_3_ctrl.md
# window_3_3_ctrl

Frame sequencer and border controller for the 3x3 line-buffer window generator. It sits beside the window, watching the same upstream pixel strobe and the window's centre-tap stream. It tracks frame progress and the centre-pixel row/column, and re-emits the 72-bit window one cycle later with a 9-bit tap-validity mask, optional zero padding at the image border, frame-done and error strobes. Downstream 3x3 filters consume its outputs instead of the raw window.

## Interface
Parameters:
- IMG_W, 720: active pixels per line.
- IMG_H, 576: active lines per frame.
- PERIOD_X, 864: clocks per line; must equal the window generator's line delay.
- PAD_ZERO, 1: 1 = masked taps forced to 0 in odata_3_3; 0 = taps passed unmodified.

Ports:
- iclk  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- ifs  in  1  frame-start pulse, coincident with the first ivalid of a frame
- ivalid  in  1  upstream pixel strobe, the same signal driving the window input
- wvalid  in  1  window centre-tap valid
- wdata  in  72  window taps; byte 8 (MSB) to byte 0 = tap11,12,13,21,22,23,31,32,33
- ovalid  out  1  registered wvalid, gated by state
- odata_3_3  out  72  registered, optionally padded taps
- omask  out  9  bit k = 1 when wdata byte k lies inside the image
- ocol  out  11  centre column, 0..IMG_W-1
- orow  out  10  centre row, 0..IMG_H-1
- oframe_done  out  1  one-cycle pulse with the last centre pixel of a frame
- oerr  out  1  one-cycle protocol-error pulse
- obusy  out  1  high in ACTIVE or DRAIN

## Operation
- Tap geometry relative to the centre (r,c):
  - tap11/12/13 = row r-1, columns c-1/c/c+1.
  - tap21/22/23 = row r.
  - tap31/32/33 = row r+1.
- Mask rules; each clears a mask bit:
  - r==0 clears bits 8,7,6.
  - r==IMG_H-1 clears bits 2,1,0.
  - c==0 clears bits 8,5,2.
  - c==IMG_W-1 clears bits 6,3,0.
  - Bit 4 is always 1 when ovalid is high.
- States:
  - IDLE: counters at 0, ovalid=0. ifs & ivalid moves to ACTIVE; that pixel is counted as input pixel 1.
  - ACTIVE: the input counter counts ivalid. Reaching IMG_W*IMG_H moves to DRAIN. The centre counter runs in parallel.
  - DRAIN: ivalid ignored except for error detection. A drain timer counts clocks. The centre pixel (IMG_W-1, IMG_H-1) with wvalid pulses oframe_done and returns to IDLE.
- Centre counter:
  - Advances on wvalid only while state != IDLE.
  - ocol wraps IMG_W-1 to 0 and increments orow.
  - wvalid in IDLE is ignored: ovalid stays 0 and no counting occurs.
- Errors: each pulses oerr once.
  - ifs in ACTIVE or DRAIN: restart ACTIVE; counters reload as for a new frame.
  - ivalid in DRAIN: no state change.
  - Drain timer reaching 2*PERIOD_X: go to IDLE with no oframe_done.
- Simultaneous last centre pixel and ifs in DRAIN: oframe_done pulses, no oerr, and the next frame starts (ACTIVE).
- Arithmetic:
  - The input counter is clog2(IMG_W*IMG_H+1) bits.
  - The drain timer is clog2(2*PERIOD_X+1) bits.
  - All comparisons are unsigned.

## Timing
- Reset (rst_i low, asynchronous):
  - state IDLE.
  - ovalid, omask, odata_3_3, ocol, orow, oframe_done, oerr and obusy all 0.
- Latency: all outputs are registered, 1 cycle after the wvalid/wdata they describe. ocol/orow/omask are aligned with ovalid.
- ocol/orow hold their last value while ovalid=0.
- obusy rises the cycle after the accepted ifs. It falls the cycle after the oframe_done cycle or the timeout.
- No back-pressure: the block never stalls the stream.
- Reset asserted mid-frame aborts with no pulses. After release, the block waits in IDLE for the next ifs.

## Structure
- Shared package: tap-index constants TAP11..TAP33 (8..0) and the mask constants MASK_TOP, MASK_BOT, MASK_LEFT, MASK_RIGHT, plus the state encoding (IDLE, ACTIVE, DRAIN).
- One sub-module, window_pos_cnt: a wrapping column/row counter with enable, load and last-pixel flag. It is instantiated for the centre counter.
- The mask/pad logic stays inline.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PERIOD_X=6, PAD_ZERO=1 unless stated.
- Reset check: hold rst_i low mid-frame -> all outputs 0 immediately, regardless of clock. Release, then feed wvalid with no ifs -> ovalid stays 0.
- Full frame: 12 contiguous ivalid pixels with ifs on the first, window model attached.
  - First ovalid: ocol=0, orow=0, omask=9'h01B.
  - Centre (1,1): omask=9'h1FF.
  - Last centre (3,2): omask=9'h1B0 and oframe_done=1 in the same cycle.
- Padding: wdata=72'hFF..FF at centre (0,0) -> odata_3_3 bytes 8,7,6,5,2 = 0, others 8'hFF. The same with PAD_ZERO=0 -> all 8'hFF, mask unchanged.
- Mid-frame ifs: ifs pulse after 5 pixels -> oerr pulses once. The next ovalid shows ocol=0, orow=0 and the frame completes normally.
- ivalid during DRAIN -> oerr pulses once and oframe_done still occurs.
- Timeout: remove the window so wvalid=0 -> oerr exactly 12 cycles after entering DRAIN, obusy falls, and no oframe_done.
